alu_reservation_station: RTL and testbench

Out-of-order ALU reservation station sitting between the rename/issue stage and the ALU execute stage. It holds up to DEPTH renamed ALU operations in `alu_res_stat_entry` format, snoops the common data bus (CDB) for outstanding source operands, and dispatches one operand-complete operation per cycle to the ALU. It is flushed wholesale on branch misprediction recovery.

---
 rtl/alu_reservation_station.sv | 152 +++++++++++++++
 tb/tb_alu_reservation_station.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds renamed ALU ops, snoops the CDB for pending operands and
// dispatches the lowest-index operand-complete entry each cycle.
module alu_reservation_station #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CNT_BITS = 2,
    parameter int unsigned TAG_BITS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          in_alu_ctl,
    input  logic [TAG_BITS-1:0] in_tag,
    input  logic [31:0]         in_v_1,
    input  logic [31:0]         in_v_2,
    input  logic [TAG_BITS:0]   in_q_1,
    input  logic [TAG_BITS:0]   in_q_2,
    input  logic                cdb_valid,
    input  logic [TAG_BITS-1:0] cdb_tag,
    input  logic [31:0]         cdb_value,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          out_alu_ctl,
    output logic [TAG_BITS-1:0] out_tag,
    output logic [31:0]         out_v_1,
    output logic [31:0]         out_v_2,
    output logic [CNT_BITS-1:0] count
);

    localparam int unsigned IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [4:0]          ctl_q [DEPTH];
    logic [4:0]          ctl_d [DEPTH];
    logic [TAG_BITS-1:0] tag_q [DEPTH];
    logic [TAG_BITS-1:0] tag_d [DEPTH];
    logic [31:0]         v1_q  [DEPTH];
    logic [31:0]         v1_d  [DEPTH];
    logic [31:0]         v2_q  [DEPTH];
    logic [31:0]         v2_d  [DEPTH];
    logic [TAG_BITS:0]   q1_q  [DEPTH];
    logic [TAG_BITS:0]   q1_d  [DEPTH];
    logic [TAG_BITS:0]   q2_q  [DEPTH];
    logic [TAG_BITS:0]   q2_d  [DEPTH];

    logic [DEPTH-1:0]    ready;
    logic                any_ready;
    logic [IDX_BITS-1:0] sel_idx;
    logic [IDX_BITS-1:0] free_idx;
    logic                do_alloc;
    logic                do_dispatch;
    logic                byp_1, byp_2;

    always_comb begin
        ready     = '0;
        any_ready = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        count     = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            ready[i] = valid_q[i] && !q1_q[i][TAG_BITS] && !q2_q[i][TAG_BITS];
            if (ready[i]) begin
                any_ready = 1'b1;
                sel_idx   = IDX_BITS'(i);
            end
            if (!valid_q[i]) begin
                free_idx = IDX_BITS'(i);
            end
            count = count + CNT_BITS'(valid_q[i]);
        end
    end

    assign in_ready    = count < CNT_BITS'(DEPTH);
    assign out_valid   = any_ready && !flush;
    assign do_alloc    = in_valid && in_ready;
    assign do_dispatch = out_valid && out_ready;

    assign out_alu_ctl = any_ready ? ctl_q[sel_idx] : '0;
    assign out_tag     = any_ready ? tag_q[sel_idx] : '0;
    assign out_v_1     = any_ready ? v1_q[sel_idx]  : '0;
    assign out_v_2     = any_ready ? v2_q[sel_idx]  : '0;

    // Operand produced on the CDB in the very cycle it is issued.
    assign byp_1 = cdb_valid && in_q_1[TAG_BITS] && (in_q_1[TAG_BITS-1:0] == cdb_tag);
    assign byp_2 = cdb_valid && in_q_2[TAG_BITS] && (in_q_2[TAG_BITS-1:0] == cdb_tag);

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ctl_d[i] = ctl_q[i];
            tag_d[i] = tag_q[i];
            v1_d[i]  = v1_q[i];
            v2_d[i]  = v2_q[i];
            q1_d[i]  = q1_q[i];
            q2_d[i]  = q2_q[i];

            if (cdb_valid && valid_q[i]) begin
                if (q1_q[i][TAG_BITS] && (q1_q[i][TAG_BITS-1:0] == cdb_tag)) begin
                    v1_d[i] = cdb_value;
                    q1_d[i] = '0;
                end
                if (q2_q[i][TAG_BITS] && (q2_q[i][TAG_BITS-1:0] == cdb_tag)) begin
                    v2_d[i] = cdb_value;
                    q2_d[i] = '0;
                end
            end

            if (do_dispatch && (sel_idx == IDX_BITS'(i))) begin
                valid_d[i] = 1'b0;
            end

            if (do_alloc && (free_idx == IDX_BITS'(i))) begin
                valid_d[i] = 1'b1;
                ctl_d[i]   = in_alu_ctl;
                tag_d[i]   = in_tag;
                v1_d[i]    = byp_1 ? cdb_value : in_v_1;
                v2_d[i]    = byp_2 ? cdb_value : in_v_2;
                q1_d[i]    = byp_1 ? '0 : in_q_1;
                q2_d[i]    = byp_2 ? '0 : in_q_2;
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ctl_q[i] <= '0;
                tag_q[i] <= '0;
                v1_q[i]  <= '0;
                v2_q[i]  <= '0;
                q1_q[i]  <= '0;
                q2_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ctl_q[i] <= ctl_d[i];
                tag_q[i] <= tag_d[i];
                v1_q[i]  <= v1_d[i];
                v2_q[i]  <= v2_d[i];
                q1_q[i]  <= q1_d[i];
                q2_q[i]  <= q2_d[i];
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed table-driven bench for alu_reservation_station; each row gives the inputs for one
// cycle and the outputs expected just before that cycle's rising edge.
module tb_alu_reservation_station;

    localparam logic [4:0] ADD = 5'd1;
    localparam logic [4:0] SUB = 5'd2;
    localparam logic [4:0] AND = 5'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_alu_ctl = '0;
    logic [0:0]  in_tag = '0;
    logic [31:0] in_v_1 = '0;
    logic [31:0] in_v_2 = '0;
    logic [1:0]  in_q_1 = '0;
    logic [1:0]  in_q_2 = '0;
    logic        cdb_valid = 1'b0;
    logic [0:0]  cdb_tag = '0;
    logic [31:0] cdb_value = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_alu_ctl;
    logic [0:0]  out_tag;
    logic [31:0] out_v_1;
    logic [31:0] out_v_2;
    logic [1:0]  count;

    int tests = 0;
    int fails = 0;

    alu_reservation_station #(.DEPTH(2), .CNT_BITS(2), .TAG_BITS(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_alu_ctl (in_alu_ctl),
        .in_tag     (in_tag),
        .in_v_1     (in_v_1),
        .in_v_2     (in_v_2),
        .in_q_1     (in_q_1),
        .in_q_2     (in_q_2),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_value  (cdb_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_alu_ctl(out_alu_ctl),
        .out_tag    (out_tag),
        .out_v_1    (out_v_1),
        .out_v_2    (out_v_2),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  ctl;
        logic [0:0]  tag;
        logic [31:0] v1;
        logic [1:0]  q1;
        logic [31:0] v2;
        logic [1:0]  q2;
        logic        cv;
        logic [0:0]  ctag;
        logic [31:0] cval;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [4:0]  e_ctl;
        logic [0:0]  e_tag;
        logic [31:0] e_v1;
        logic [31:0] e_v2;
        logic [1:0]  e_cnt;
        logic        e_ir;
        logic        chk_data;
    } vec_t;

    vec_t vecs[40];
    int   n_vec = 0;

    task automatic add(input logic iv, input logic [4:0] ctl, input logic [0:0] tag,
                       input logic [31:0] v1, input logic [1:0] q1,
                       input logic [31:0] v2, input logic [1:0] q2,
                       input logic cv, input logic [0:0] ctag, input logic [31:0] cval,
                       input logic ordy, input logic fl,
                       input logic e_ov, input logic [4:0] e_ctl, input logic [0:0] e_tag,
                       input logic [31:0] e_v1, input logic [31:0] e_v2,
                       input logic [1:0] e_cnt, input logic e_ir, input logic chk_data);
        vecs[n_vec] = '{iv, ctl, tag, v1, q1, v2, q2, cv, ctag, cval, ordy, fl,
                        e_ov, e_ctl, e_tag, e_v1, e_v2, e_cnt, e_ir, chk_data};
        n_vec++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        cdb_valid = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        //   iv ctl  tg v1        q1     v2        q2     cv tg cval      rdy fl | ov ctl tg v1  v2  cnt ir chk
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 0, 0, 0,        0, 0,   0, 0,   0, 0, 0, 0, 1, 1);
        // Ready issue then dispatch.
        add(1, ADD, 0, 5,        2'b00, 7,        2'b00, 0, 0, 0,        0, 0,   0, 0,   0, 0, 0, 0, 1, 1);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 0, 0, 0,        1, 0,   1, ADD, 0, 5, 7, 1, 1, 1);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 0, 0, 0,        0, 0,   0, 0,   0, 0, 0, 0, 1, 1);
        // CDB wake-up of operand 1.
        add(1, SUB, 1, 32'hdead, 2'b11, 3,        2'b00, 0, 0, 0,        0, 0,   0, 0,   0, 0, 0, 0, 1, 1);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 0, 0, 0,        0, 0,   0, 0,   0, 0, 0, 1, 1, 1);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 1, 0, 32'h55,   0, 0,   0, 0,   0, 0, 0, 1, 1, 1);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 1, 1, 32'h10,   0, 0,   0, 0,   0, 0, 0, 1, 1, 1);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 0, 0, 0,        1, 0,   1, SUB, 1, 32'h10, 3, 1, 1, 1);
        // Bypass at allocation.
        add(1, ADD, 0, 9,        2'b00, 0,        2'b10, 1, 0, 32'hABCD, 0, 0,   0, 0,   0, 0, 0, 0, 1, 1);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 0, 0, 0,        1, 0,   1, ADD, 0, 9, 32'hABCD, 1, 1, 1);
        // Fill with pending operands; third issue dropped.
        add(1, SUB, 0, 0,        2'b11, 1,        2'b00, 0, 0, 0,        0, 0,   0, 0,   0, 0, 0, 0, 1, 1);
        add(1, ADD, 1, 4,        2'b00, 0,        2'b10, 0, 0, 0,        0, 0,   0, 0,   0, 0, 0, 1, 1, 1);
        add(1, AND, 0, 32'h77,   2'b00, 32'h88,   2'b00, 0, 0, 0,        0, 0,   0, 0,   0, 0, 0, 2, 0, 1);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 0, 0, 0,        0, 0,   0, 0,   0, 0, 0, 2, 0, 1);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 1, 0, 32'h20,   0, 0,   0, 0,   0, 0, 0, 2, 0, 1);
        // Stall holds entry 1 stable, then entry 0 wakes and preempts.
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 0, 0, 0,        0, 0,   1, ADD, 1, 4, 32'h20, 2, 0, 1);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 0, 0, 0,        0, 0,   1, ADD, 1, 4, 32'h20, 2, 0, 1);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 1, 1, 32'h30,   0, 0,   1, ADD, 1, 4, 32'h20, 2, 0, 1);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 0, 0, 0,        0, 0,   1, SUB, 0, 32'h30, 1, 2, 0, 1);
        // Flush with concurrent issue, CDB and dispatch request.
        add(1, AND, 0, 1,        2'b00, 2,        2'b00, 1, 0, 32'h99,   1, 1,   0, 0,   0, 0, 0, 2, 0, 0);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 0, 0, 0,        0, 0,   0, 0,   0, 0, 0, 0, 1, 1);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 0, 0, 0,        0, 0,   0, 0,   0, 0, 0, 0, 1, 1);
        // Simultaneous allocate and dispatch keeps the count.
        add(1, ADD, 0, 1,        2'b00, 2,        2'b00, 0, 0, 0,        0, 0,   0, 0,   0, 0, 0, 0, 1, 1);
        add(1, SUB, 1, 3,        2'b00, 4,        2'b00, 0, 0, 0,        1, 0,   1, ADD, 0, 1, 2, 1, 1, 1);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 0, 0, 0,        1, 0,   1, SUB, 1, 3, 4, 1, 1, 1);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 0, 0, 0,        0, 0,   0, 0,   0, 0, 0, 0, 1, 1);
        // Flush overrides allocation into a free slot.
        add(1, ADD, 0, 6,        2'b00, 6,        2'b00, 0, 0, 0,        0, 0,   0, 0,   0, 0, 0, 0, 1, 1);
        add(1, SUB, 1, 8,        2'b00, 8,        2'b00, 1, 1, 32'h1,    0, 1,   0, 0,   0, 0, 0, 1, 1, 0);
        add(0, 0,   0, 0,        2'b00, 0,        2'b00, 0, 0, 0,        0, 0,   0, 0,   0, 0, 0, 0, 1, 1);

        // Reset state.
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_data", {out_alu_ctl, out_tag, out_v_1, out_v_2}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < n_vec; i++) begin
            @(negedge clk);
            in_valid   = vecs[i].iv;
            in_alu_ctl = vecs[i].ctl;
            in_tag     = vecs[i].tag;
            in_v_1     = vecs[i].v1;
            in_q_1     = vecs[i].q1;
            in_v_2     = vecs[i].v2;
            in_q_2     = vecs[i].q2;
            cdb_valid  = vecs[i].cv;
            cdb_tag    = vecs[i].ctag;
            cdb_value  = vecs[i].cval;
            out_ready  = vecs[i].ordy;
            flush      = vecs[i].fl;
            #1;
            check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            check($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
            check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d_out_data", i), {out_alu_ctl, out_tag, out_v_1, out_v_2},
                      {vecs[i].e_ctl, vecs[i].e_tag, vecs[i].e_v1, vecs[i].e_v2});
            end
        end

        // Asynchronous reset mid-operation discards entries immediately.
        @(negedge clk);
        idle_inputs();
        in_valid   = 1'b1;
        in_alu_ctl = ADD;
        in_tag     = 1'b0;
        in_v_1     = 32'h11;
        in_v_2     = 32'h22;
        in_q_1     = 2'b00;
        in_q_2     = 2'b00;
        @(negedge clk);
        idle_inputs();
        #1;
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        check("pre_rst_count", 64'(count), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_data", {out_alu_ctl, out_tag, out_v_1, out_v_2}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_count", 64'(count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
